ram_arbiter_2p: RTL and testbench
=================================

Name: ram_arbiter_2p

Overview:
- Two-requester arbiter that shares one 16x8 single-port RAM with asynchronous read and synchronous write.
- Round-robin arbitration, with an optional bounded lock so one requester can hold the port for back-to-back accesses.
- Sits between two client engines and the RAM instance. It drives the RAM address, data and write-enable, and returns registered read data to each client.

Parameters:
- AW, 4, RAM address width (16 words)
- DW, 8, RAM data width
- MAX_LOCK, 4, max consecutive granted cycles under lock (>=1; 1 disables locking in effect)

Ports:
- clk  input  1  clock, all state on posedge
- rst  input  1  asynchronous, active-high reset
- a_req  input  1  requester A wants an access this cycle
- a_we  input  1  1=write, 0=read
- a_lock  input  1  request to keep ownership after this grant
- a_addr  input  AW  access address
- a_wdata  input  DW  write data
- a_gnt  output  1  combinational grant; access commits at this clk edge
- a_rdata  output  DW  registered read data
- a_rvalid  output  1  one-cycle pulse, a_rdata updated
- b_req, b_we, b_lock, b_addr, b_wdata, b_gnt, b_rdata, b_rvalid: same as A, for requester B
- ram_add  output  AW  to RAM address
- ram_din  output  DW  to RAM write data
- ram_wr_en  output  1  to RAM write enable
- ram_dout  input  DW  from RAM asynchronous read data

Behaviour:
- Reset (async, immediate):
  - state=IDLE, lock_cnt=0, last_grant=B (so A wins the first conflict)
  - a_rdata=b_rdata=0, a_rvalid=b_rvalid=0
- State: IDLE, LOCK_A, LOCK_B. lock_cnt is ceil(log2(MAX_LOCK+1)) bits.
- Grant logic (combinational, at most one gnt high):
  - IDLE: single requester wins. On conflict, the requester that is not last_grant wins.
  - LOCK_X: if x_req, X wins unconditionally. If !x_req, the other requester wins if requesting.
- RAM drive:
  - Winner's addr/wdata go to ram_add/ram_din; ram_wr_en = winner's we.
  - No grant: ram_wr_en=0, ram_add=0, ram_din=0.
- Writes commit at the granting edge. A read in the same cycle as a write to the same address is impossible, since there is a single port.
- Reads:
  - On a granted read, ram_dout is captured into x_rdata at that edge.
  - x_rvalid=1 for exactly the following cycle. Latency: gnt cycle N -> rdata/rvalid in cycle N+1.
  - x_rdata holds until the next granted read by X. Writes never pulse rvalid.
- last_grant updates to the winner on every grant; it holds when there is no grant.
- Lock transitions (evaluated at the edge, X = winner):
  - Grant with x_lock=0 -> IDLE, lock_cnt=0.
  - Grant with x_lock=1 from IDLE or LOCK_Y -> LOCK_X, lock_cnt=1. If MAX_LOCK==1 -> IDLE instead.
  - Grant with x_lock=1 in LOCK_X -> lock_cnt+1. On reaching MAX_LOCK -> IDLE, lock_cnt=0, and last_grant=X gives the other requester priority next.
  - LOCK_X with !x_req -> IDLE (other may be granted that same cycle, per the rules above).
  - No grants at all -> IDLE.
- Starvation bound: a continuously requesting client waits at most MAX_LOCK cycles.
- Reset mid-lock or mid-read clears everything. No rvalid pulse is emitted for a read granted in the cycle reset asserts.
- No back-pressure on read return; clients must accept rvalid.

Decomposition:
- Shared package: AW/DW defaults, state encoding enum {IDLE, LOCK_A, LOCK_B}, requester-id constants REQ_A/REQ_B.
- One natural sub-module, rr_pick2: a 2-way round-robin picker (inputs req[1:0], last; output one-hot gnt). The lock FSM, counter, muxing and read-return registers stay in the top.

Test Plan:
- Reset then single access: A writes 0xAA@3, later A reads @3 -> a_gnt same cycle, a_rvalid one cycle later, a_rdata=0xAA, b_rvalid stays 0.
- Conflict RR: A and B both read continuously (A@3, B@7, RAM preloaded 0xAA/0x55) -> grants alternate A,B,A,B starting with A. Each rvalid pulses every other cycle with 0xAA/0x55.
- Lock bound (MAX_LOCK=4): A req+lock continuously writing 0x10..0x17 to @0..7, B requesting -> A granted 4 consecutive cycles, then B granted 1, then A granted 4 again. RAM contents match the granted writes only.
- Lock release: A locks 2 cycles then drops req while B requests -> B granted in the first cycle A is idle; state returns to IDLE.
- Idle and write-only: no req -> ram_wr_en=0, ram_add=0. B write 0x55@7 -> b_gnt=1, no b_rvalid; subsequent B read @7 returns 0x55.
- Async reset mid-lock: assert rst during LOCK_A with lock_cnt=2 -> gnt, rvalid and rdata go to 0 immediately. After release, a conflict grants A first.

Source files
------------

// File: rtl/ram_arbiter_2p_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
package ram_arbiter_2p_pkg;

    localparam int AW_DEF       = 4;
    localparam int DW_DEF       = 8;
    localparam int MAX_LOCK_DEF = 4;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } arb_state_t;

    // One-hot grant vector for a single requester id (bit 0 = A, bit 1 = B).
    function automatic logic [1:0] id_onehot(input logic id);
        return (id == REQ_B) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ram_arbiter_2p_rr_pick2.sv
// Two-way round-robin picker: the requester that did not win last time
// takes a conflict; a lone requester always wins.
module rr_pick2
    import ram_arbiter_2p_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        unique case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = id_onehot(~i_last);
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_arbiter_2p.sv
// Round-robin arbiter with bounded lock sharing one async-read,
// sync-write single-port RAM between two clients.
module ram_arbiter_2p
    import ram_arbiter_2p_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_LOCK = MAX_LOCK_DEF
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          a_req,
    input  logic          a_we,
    input  logic          a_lock,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic [DW-1:0] a_rdata,
    output logic          a_rvalid,

    input  logic          b_req,
    input  logic          b_we,
    input  logic          b_lock,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic [DW-1:0] b_rdata,
    output logic          b_rvalid,

    output logic [AW-1:0] ram_add,
    output logic [DW-1:0] ram_din,
    output logic          ram_wr_en,
    input  logic [DW-1:0] ram_dout
);

    localparam int CW = $clog2(MAX_LOCK + 1);

    arb_state_t    r_state;
    logic [CW-1:0] r_lock_cnt;
    logic          r_last;
    logic [DW-1:0] r_a_rdata;
    logic [DW-1:0] r_b_rdata;
    logic          r_a_rvalid;
    logic          r_b_rvalid;

    logic [1:0]    w_rr_gnt;
    logic [1:0]    w_gnt;
    logic          w_any;
    logic          w_win;
    logic          w_win_we;
    logic          w_win_lock;
    logic          w_own_lock;
    logic [CW-1:0] w_cnt_inc;

    rr_pick2 u_pick (
        .i_req  ({b_req, a_req}),
        .i_last (r_last),
        .o_gnt  (w_rr_gnt)
    );

    // Grant is forced low while reset is held so nothing reaches the RAM.
    always_comb begin
        w_gnt = 2'b00;
        if (!rst) begin
            unique case (r_state)
                LOCK_A:  w_gnt = a_req ? 2'b01 : {b_req, 1'b0};
                LOCK_B:  w_gnt = b_req ? 2'b10 : {1'b0, a_req};
                default: w_gnt = w_rr_gnt;
            endcase
        end
    end

    assign w_any      = |w_gnt;
    assign w_win      = w_gnt[1];
    assign w_win_we   = (w_win == REQ_B) ? b_we   : a_we;
    assign w_win_lock = (w_win == REQ_B) ? b_lock : a_lock;
    assign w_own_lock = ((w_win == REQ_A) && (r_state == LOCK_A)) ||
                        ((w_win == REQ_B) && (r_state == LOCK_B));
    assign w_cnt_inc  = r_lock_cnt + CW'(1);

    assign a_gnt = w_gnt[0];
    assign b_gnt = w_gnt[1];

    always_comb begin
        ram_add   = '0;
        ram_din   = '0;
        ram_wr_en = 1'b0;
        if (w_any) begin
            ram_add   = (w_win == REQ_B) ? b_addr  : a_addr;
            ram_din   = (w_win == REQ_B) ? b_wdata : a_wdata;
            ram_wr_en = w_win_we;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_lock_cnt <= '0;
            r_last     <= REQ_B;
            r_a_rdata  <= '0;
            r_b_rdata  <= '0;
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
        end else begin
            r_a_rvalid <= w_gnt[0] & ~a_we;
            r_b_rvalid <= w_gnt[1] & ~b_we;
            if (w_gnt[0] && !a_we) begin
                r_a_rdata <= ram_dout;
            end
            if (w_gnt[1] && !b_we) begin
                r_b_rdata <= ram_dout;
            end
            if (w_any) begin
                r_last <= w_win;
            end

            if (!w_any || !w_win_lock) begin
                r_state    <= IDLE;
                r_lock_cnt <= '0;
            end else if (w_own_lock) begin
                // Hitting the bound hands priority to the other side.
                if (w_cnt_inc == CW'(MAX_LOCK)) begin
                    r_state    <= IDLE;
                    r_lock_cnt <= '0;
                end else begin
                    r_lock_cnt <= w_cnt_inc;
                end
            end else if (MAX_LOCK == 1) begin
                r_state    <= IDLE;
                r_lock_cnt <= '0;
            end else begin
                r_state    <= (w_win == REQ_B) ? LOCK_B : LOCK_A;
                r_lock_cnt <= CW'(1);
            end
        end
    end

    assign a_rdata  = r_a_rdata;
    assign b_rdata  = r_b_rdata;
    assign a_rvalid = r_a_rvalid;
    assign b_rvalid = r_b_rvalid;

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Directed bench for ram_arbiter_2p with a behavioural 16x8 RAM.
module tb_ram_arbiter_2p;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_req, a_we, a_lock;
    logic [3:0] a_addr;
    logic [7:0] a_wdata;
    logic       a_gnt, a_rvalid;
    logic [7:0] a_rdata;
    logic       b_req, b_we, b_lock;
    logic [3:0] b_addr;
    logic [7:0] b_wdata;
    logic       b_gnt, b_rvalid;
    logic [7:0] b_rdata;
    logic [3:0] ram_add;
    logic [7:0] ram_din;
    logic       ram_wr_en;
    logic [7:0] ram_dout;

    logic [7:0] mem [16] = '{default: 8'h00};

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_add] <= ram_din;
    end
    assign ram_dout = mem[ram_add];

    ram_arbiter_2p #(.AW(4), .DW(8), .MAX_LOCK(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_lock   (a_lock),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_gnt    (a_gnt),
        .a_rdata  (a_rdata),
        .a_rvalid (a_rvalid),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_lock   (b_lock),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_gnt    (b_gnt),
        .b_rdata  (b_rdata),
        .b_rvalid (b_rvalid),
        .ram_add  (ram_add),
        .ram_din  (ram_din),
        .ram_wr_en(ram_wr_en),
        .ram_dout (ram_dout)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic ar, input logic aw, input logic al,
                         input logic [3:0] aa, input logic [7:0] ad,
                         input logic br, input logic bw, input logic bl,
                         input logic [3:0] ba, input logic [7:0] bd);
        a_req = ar; a_we = aw; a_lock = al; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_lock = bl; b_addr = ba; b_wdata = bd;
    endtask

    task automatic idle();
        drive(0, 0, 0, 4'h0, 8'h00, 0, 0, 0, 4'h0, 8'h00);
    endtask

    initial begin
        int  ai;
        logic exp_a;
        rst = 1'b1;
        idle();
        @(negedge clk);
        @(negedge clk);
        check("rst_a_gnt", a_gnt, 0);
        check("rst_b_gnt", b_gnt, 0);
        check("rst_a_rvalid", a_rvalid, 0);
        check("rst_b_rvalid", b_rvalid, 0);
        check("rst_a_rdata", a_rdata, 8'h00);
        check("rst_b_rdata", b_rdata, 8'h00);
        check("rst_wr_en", ram_wr_en, 0);

        // single accesses
        @(negedge clk);
        rst = 1'b0;
        drive(1, 1, 0, 4'd3, 8'hAA, 0, 0, 0, 4'd0, 8'h00);
        #1;
        check("wrA_a_gnt", a_gnt, 1);
        check("wrA_b_gnt", b_gnt, 0);
        check("wrA_wr_en", ram_wr_en, 1);
        check("wrA_add", ram_add, 4'd3);
        check("wrA_din", ram_din, 8'hAA);
        @(negedge clk);
        check("wrA_no_rvalid", a_rvalid, 0);
        check("wrA_mem3", mem[3], 8'hAA);
        drive(0, 0, 0, 4'd0, 8'h00, 1, 1, 0, 4'd7, 8'h55);
        #1;
        check("wrB_b_gnt", b_gnt, 1);
        check("wrB_add", ram_add, 4'd7);
        @(negedge clk);
        check("wrB_no_rvalid", b_rvalid, 0);
        check("wrB_mem7", mem[7], 8'h55);
        idle();
        #1;
        check("idle_wr_en", ram_wr_en, 0);
        check("idle_add", ram_add, 4'd0);
        check("idle_din", ram_din, 8'h00);
        check("idle_gnt", {a_gnt, b_gnt}, 2'b00);
        @(negedge clk);
        drive(1, 0, 0, 4'd3, 8'h00, 0, 0, 0, 4'd0, 8'h00);
        #1;
        check("rdA_a_gnt", a_gnt, 1);
        check("rdA_wr_en", ram_wr_en, 0);
        @(negedge clk);
        check("rdA_rvalid", a_rvalid, 1);
        check("rdA_rdata", a_rdata, 8'hAA);
        check("rdA_b_rvalid", b_rvalid, 0);
        drive(0, 0, 0, 4'd0, 8'h00, 1, 0, 0, 4'd7, 8'h00);
        #1;
        check("rdB_b_gnt", b_gnt, 1);
        @(negedge clk);
        check("rdA_rvalid_drop", a_rvalid, 0);
        check("rdA_rdata_hold", a_rdata, 8'hAA);
        check("rdB_rvalid", b_rvalid, 1);
        check("rdB_rdata", b_rdata, 8'h55);
        idle();

        // round-robin conflict, last grant was B so A leads
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k > 0) begin
                check("rr_a_rvalid", a_rvalid, (k % 2) == 1);
                check("rr_b_rvalid", b_rvalid, (k % 2) == 0);
            end
            drive(1, 0, 0, 4'd3, 8'h00, 1, 0, 0, 4'd7, 8'h00);
            #1;
            check("rr_a_gnt", a_gnt, (k % 2) == 0);
            check("rr_b_gnt", b_gnt, (k % 2) == 1);
        end
        @(negedge clk);
        check("rr_b_rvalid_end", b_rvalid, 1);
        check("rr_b_rdata", b_rdata, 8'h55);
        check("rr_a_rdata", a_rdata, 8'hAA);
        idle();

        // lock bound: A x4, B x1, A x4
        ai = 0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k > 0) check("lk_a_rvalid", a_rvalid, 0);
            if (k == 5) begin
                check("lk_b_rvalid", b_rvalid, 1);
                check("lk_b_rdata", b_rdata, 8'h55);
            end
            drive(1, 1, 1, ai[3:0], 8'(8'h10 + ai), 1, 0, 0, 4'd7, 8'h00);
            exp_a = (k != 4);
            #1;
            check("lk_a_gnt", a_gnt, exp_a);
            check("lk_b_gnt", b_gnt, !exp_a);
            check("lk_wr_en", ram_wr_en, exp_a);
            if (exp_a) ai++;
        end
        @(negedge clk);
        idle();
        for (int i = 0; i < 8; i++) begin
            check("lk_mem", mem[i], 8'(8'h10 + i));
        end
        check("lk_mem8", mem[8], 8'h00);

        // lock release: A locks two cycles then drops
        @(negedge clk);
        drive(1, 1, 1, 4'd9, 8'h20, 0, 0, 0, 4'd0, 8'h00);
        #1;
        check("rel_a_gnt0", a_gnt, 1);
        @(negedge clk);
        drive(1, 1, 1, 4'd10, 8'h21, 1, 0, 0, 4'd3, 8'h00);
        #1;
        check("rel_a_gnt1", a_gnt, 1);
        check("rel_b_gnt1", b_gnt, 0);
        @(negedge clk);
        drive(0, 0, 0, 4'd0, 8'h00, 1, 0, 0, 4'd3, 8'h00);
        #1;
        check("rel_b_gnt2", b_gnt, 1);
        check("rel_a_gnt2", a_gnt, 0);
        @(negedge clk);
        check("rel_b_rvalid", b_rvalid, 1);
        check("rel_b_rdata", b_rdata, 8'h13);
        drive(1, 0, 0, 4'd9, 8'h00, 1, 0, 0, 4'd3, 8'h00);
        #1;
        check("rel_idle_a_gnt", a_gnt, 1);
        check("rel_idle_b_gnt", b_gnt, 0);
        @(negedge clk);
        check("rel_a_rdata", a_rdata, 8'h20);
        check("rel_mem10", mem[10], 8'h21);
        idle();

        // async reset while LOCK_A with count 2
        @(negedge clk);
        drive(1, 0, 1, 4'd9, 8'h00, 0, 0, 0, 4'd0, 8'h00);
        @(negedge clk);
        drive(1, 0, 1, 4'd10, 8'h00, 1, 0, 0, 4'd3, 8'h00);
        #1;
        check("ar_a_gnt1", a_gnt, 1);
        @(negedge clk);
        check("ar_pre_rvalid", a_rvalid, 1);
        check("ar_pre_rdata", a_rdata, 8'h21);
        drive(1, 0, 1, 4'd9, 8'h00, 1, 0, 0, 4'd3, 8'h00);
        #1;
        check("ar_a_gnt2", a_gnt, 1);
        #1;
        rst = 1'b1;
        #1;
        check("ar_gnt", {a_gnt, b_gnt}, 2'b00);
        check("ar_a_rvalid", a_rvalid, 0);
        check("ar_a_rdata", a_rdata, 8'h00);
        check("ar_b_rdata", b_rdata, 8'h00);
        check("ar_wr_en", ram_wr_en, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("ar_no_rvalid", a_rvalid, 0);
        drive(1, 0, 0, 4'd9, 8'h00, 1, 0, 0, 4'd3, 8'h00);
        #1;
        check("ar_post_a_gnt", a_gnt, 1);
        check("ar_post_b_gnt", b_gnt, 0);
        @(negedge clk);
        check("ar_post_rvalid", a_rvalid, 1);
        check("ar_post_rdata", a_rdata, 8'h20);
        #1;
        check("ar_post_b_gnt2", b_gnt, 1);
        @(negedge clk);
        idle();
        check("ar_post_b_rdata", b_rdata, 8'h13);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
